// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, controller state encoding and opcode helpers.
package alu_pkg;

  localparam logic [5:0] ALU_ADD    = 6'h00;
  localparam logic [5:0] ALU_MUL    = 6'h01;
  localparam logic [5:0] ALU_DIV    = 6'h02;
  localparam logic [5:0] ALU_MOD    = 6'h03;
  localparam logic [5:0] ALU_SLL    = 6'h04;
  localparam logic [5:0] ALU_SRL    = 6'h05;
  localparam logic [5:0] ALU_SRA    = 6'h06;
  localparam logic [5:0] ALU_SLT    = 6'h07;
  localparam logic [5:0] ALU_SLTU   = 6'h08;
  localparam logic [5:0] ALU_AND    = 6'h09;
  localparam logic [5:0] ALU_OR     = 6'h0A;
  localparam logic [5:0] ALU_NOR    = 6'h0B;
  localparam logic [5:0] ALU_LUI    = 6'h0C;
  localparam logic [5:0] ALU_MULH   = 6'h0D;
  localparam logic [5:0] ALU_MULHU  = 6'h0E;
  localparam logic [5:0] ALU_SUB    = 6'h0F;
  localparam logic [5:0] ALU_NAND   = 6'h10;
  localparam logic [5:0] ALU_XOR    = 6'h11;
  localparam logic [5:0] ALU_OP_MAX = 6'h11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  function automatic logic isDivOp(input logic [5:0] op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: accepts one op, reads operands, drives the external ALU
// for exactly one cycle, then writes the captured result back to the register file.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int IMM_W    = 16,
  parameter bit R0_ZERO  = 1'b1,
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [5:0]         instr_op,
  input  logic [RADDR_W-1:0] instr_rd,
  input  logic [RADDR_W-1:0] instr_rs,
  input  logic [RADDR_W-1:0] instr_rt,
  input  logic               instr_use_imm,
  input  logic [IMM_W-1:0]   instr_imm,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  output logic [DATA_W-1:0]  alu_regA,
  output logic [DATA_W-1:0]  alu_regB,
  output logic [5:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               done,
  output logic               zero_flag,
  output logic               err_div0,
  output logic               err_illegal
);

  state_t               state_r, nextState_s;
  logic [5:0]           op_r;
  logic [RADDR_W-1:0]   rd_r, raddr1_r, raddr2_r, rfWaddr_r;
  logic                 useImm_r;
  logic [IMM_W-1:0]     imm_r;
  logic [DATA_W-1:0]    immExt_s, opB_s;
  logic [DATA_W-1:0]    aluRegA_r, aluRegB_r, rfWdata_r;
  logic [5:0]           aluOp_r;
  logic                 div0_r, illegal_r;
  logic                 instrReady_r, rfWe_r, done_r, zeroFlag_r, errDiv0_r, errIllegal_r;
  logic                 accept_s;

  assign accept_s = instr_valid && instrReady_r;

  // Next-state logic
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) nextState_s = READ;
        else          nextState_s = IDLE;
      end
      READ:    nextState_s = EXEC;
      EXEC:    nextState_s = WB;
      WB:      nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Operand B selection with immediate extension
  always_comb begin
    immExt_s = '0;
    if (IMM_SEXT) immExt_s = {{(DATA_W-IMM_W){imm_r[IMM_W-1]}}, imm_r};
    else          immExt_s = {{(DATA_W-IMM_W){1'b0}}, imm_r};
    if (useImm_r) opB_s = immExt_s;
    else          opB_s = rf_rdata2;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= nextState_s;
  end

  // Instruction latch and read addresses, captured on the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 6'h00;
      rd_r     <= '0;
      useImm_r <= 1'b0;
      imm_r    <= '0;
      raddr1_r <= '0;
      raddr2_r <= '0;
    end else if (accept_s) begin
      op_r     <= instr_op;
      rd_r     <= instr_rd;
      useImm_r <= instr_use_imm;
      imm_r    <= instr_imm;
      raddr1_r <= instr_rs;
      raddr2_r <= instr_rt;
    end
  end

  // ALU drive is non-zero only during EXEC; exceptions are classified at the end of READ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluRegA_r <= '0;
      aluRegB_r <= '0;
      aluOp_r   <= 6'h00;
      div0_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else if (state_r == READ) begin
      aluRegA_r <= rf_rdata1;
      aluRegB_r <= opB_s;
      aluOp_r   <= op_r;
      div0_r    <= isDivOp(op_r) && (opB_s == '0);
      illegal_r <= op_r > ALU_OP_MAX;
    end else begin
      aluRegA_r <= '0;
      aluRegB_r <= '0;
      aluOp_r   <= 6'h00;
    end
  end

  // Write-back and status outputs, loaded from the ALU at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrReady_r <= 1'b1;
      rfWe_r       <= 1'b0;
      rfWaddr_r    <= '0;
      rfWdata_r    <= '0;
      done_r       <= 1'b0;
      zeroFlag_r   <= 1'b0;
      errDiv0_r    <= 1'b0;
      errIllegal_r <= 1'b0;
    end else begin
      instrReady_r <= (nextState_s == IDLE);
      if (state_r == EXEC) begin
        rfWe_r       <= !div0_r && !illegal_r && !(R0_ZERO && (rd_r == '0));
        rfWaddr_r    <= rd_r;
        rfWdata_r    <= alu_result;
        done_r       <= 1'b1;
        errDiv0_r    <= div0_r;
        errIllegal_r <= illegal_r;
        if (!div0_r && !illegal_r) zeroFlag_r <= alu_zero;
        else                       zeroFlag_r <= zeroFlag_r;
      end else begin
        rfWe_r       <= 1'b0;
        done_r       <= 1'b0;
        errDiv0_r    <= 1'b0;
        errIllegal_r <= 1'b0;
      end
    end
  end

  assign instr_ready = instrReady_r;
  assign rf_raddr1   = raddr1_r;
  assign rf_raddr2   = raddr2_r;
  assign alu_regA    = aluRegA_r;
  assign alu_regB    = aluRegB_r;
  assign alu_op      = aluOp_r;
  assign rf_we       = rfWe_r;
  assign rf_waddr    = rfWaddr_r;
  assign rf_wdata    = rfWdata_r;
  assign done        = done_r;
  assign zero_flag   = zeroFlag_r;
  assign err_div0    = errDiv0_r;
  assign err_illegal = errIllegal_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: behavioural register file and ALU, scoreboard of
// expected completions pushed at issue and popped on each done pulse.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready, instr_use_imm;
  logic [5:0]  instr_op, alu_op;
  logic [4:0]  instr_rd, instr_rs, instr_rt, rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] instr_imm;
  logic [31:0] rf_rdata1, rf_rdata2, alu_regA, alu_regB, alu_result, rf_wdata;
  logic        alu_zero, rf_we, done, zero_flag, err_div0, err_illegal;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        zero;
    logic        div0;
    logic        ill;
  } exp_t;

  exp_t        expQ[$];
  int unsigned dueQ[$];
  int unsigned accLog[$];
  int unsigned cyc = 0;
  int          total = 0, passed = 0;
  logic        zeroModel = 1'b0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_regA(alu_regA), .alu_regB(alu_regB), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .zero_flag(zero_flag), .err_div0(err_div0), .err_illegal(err_illegal)
  );

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // Reference ALU for the opcodes the bench exercises
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_result = alu_regA + alu_regB;
      ALU_SUB: alu_result = alu_regA - alu_regB;
      ALU_XOR: alu_result = alu_regA ^ alu_regB;
      ALU_DIV: alu_result = (alu_regB != 32'd0) ? alu_regA / alu_regB : 32'd0;
      ALU_MOD: alu_result = (alu_regB != 32'd0) ? alu_regA % alu_regB : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
  endtask

  // Accept tracking: done is due three cycles after the accepting cycle
  always @(posedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      dueQ.push_back(cyc + 32'd3);
      accLog.push_back(cyc);
    end
    cyc <= cyc + 32'd1;
  end

  // Completion monitor
  always @(negedge clk) begin
    exp_t        e;
    int unsigned d;
    if (!rst) begin
      if (instr_ready) begin
        chk("alu_op_idle", {26'd0, alu_op}, 32'd0);
        chk("alu_operands_idle", alu_regA | alu_regB, 32'd0);
      end
      if (rf_we && !done) chk("we_without_done", 32'd1, 32'd0);
      if (done) begin
        if (expQ.size() == 0 || dueQ.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          d = dueQ.pop_front();
          chk("latency", cyc, d);
          chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
          if (e.we) begin
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
            chk("rf_wdata", rf_wdata, e.wdata);
          end
          chk("zero_flag", {31'd0, zero_flag}, {31'd0, e.zero});
          chk("err_div0", {31'd0, err_div0}, {31'd0, e.div0});
          chk("err_illegal", {31'd0, err_illegal}, {31'd0, e.ill});
        end
      end
    end
  end

  task automatic setOp(input logic [5:0] op, input logic [4:0] rd, rs, rt, input logic ui,
                       input logic [15:0] imm, input logic track, input logic we,
                       input logic [31:0] wd, input logic z, dz, il);
    exp_t e;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
    instr_use_imm = ui; instr_imm = imm;
    if (track) begin
      if (!dz && !il) zeroModel = z;
      e = '{we: we, waddr: rd, wdata: wd, zero: zeroModel, div0: dz, ill: il};
      expQ.push_back(e);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rd, rs, rt, input logic ui,
                       input logic [15:0] imm, input logic track, input logic we,
                       input logic [31:0] wd, input logic z, dz, il);
    int n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", {31'd0, instr_ready}, 32'd1);
    setOp(op, rd, rs, rt, ui, imm, track, we, wd, z, dz, il);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("drain", expQ.size(), 32'd0);
    @(negedge clk);
  endtask

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout total=%0d passed=%0d", total, passed);
    $fatal(1, "time limit reached");
  end

  initial begin
    logic [5:0]  bOp [3];
    logic [4:0]  bRs [3];
    logic [4:0]  bRt [3];
    logic [31:0] bWd [3];
    int          busy;
    bOp = '{ALU_ADD, ALU_XOR, ALU_SUB};
    bRs = '{5'd1, 5'd1, 5'd2};
    bRt = '{5'd2, 5'd2, 5'd1};
    bWd = '{32'd12, 32'd2, 32'd2};
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[4] = 32'd9; rf[5] = 32'd10;
    rst = 1'b1; instr_valid = 1'b0;
    setOp(6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_alu_op", {26'd0, alu_op}, 32'd0);
    chk("rst_raddr", {22'd0, rf_raddr1, rf_raddr2}, 32'd0);
    chk("rst_waddr_wdata", {27'd0, rf_waddr} | rf_wdata, 32'd0);
    chk("rst_flags", {29'd0, zero_flag, err_div0, err_illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(ALU_ADD, 5'd3,  5'd1, 5'd2, 1'b0, 16'h0000, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
    issue(ALU_SUB, 5'd7,  5'd4, 5'd0, 1'b1, 16'h0009, 1'b1, 1'b1, 32'd0,  1'b1, 1'b0, 1'b0);
    issue(ALU_DIV, 5'd8,  5'd5, 5'd6, 1'b0, 16'h0000, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0);
    issue(6'h3F,   5'd10, 5'd1, 5'd2, 1'b0, 16'h0000, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1);
    issue(ALU_MOD, 5'd8,  5'd5, 5'd0, 1'b1, 16'h0000, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0);
    issue(ALU_SUB, 5'd9,  5'd4, 5'd0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 32'h0000000A, 1'b0, 1'b0, 1'b0);
    issue(ALU_SUB, 5'd0,  5'd1, 5'd1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 1'b0);
    issue(ALU_DIV, 5'd11, 5'd5, 5'd0, 1'b1, 16'h0003, 1'b1, 1'b1, 32'd3,  1'b0, 1'b0, 1'b0);
    drain();

    // Back-to-back with instr_valid held high
    accLog.delete();
    setOp(bOp[0], 5'd12, bRs[0], bRt[0], 1'b0, 16'h0000, 1'b1, 1'b1, bWd[0], 1'b0, 1'b0, 1'b0);
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) instr_valid = 1'b0;
      busy = 0;
      while (!instr_ready && busy < 10) begin busy++; @(negedge clk); end
      chk("busy_cycles", busy, 32'd3);
      if (k < 2)
        setOp(bOp[k+1], 5'd13 + 5'(k), bRs[k+1], bRt[k+1], 1'b0, 16'h0000, 1'b1, 1'b1,
              bWd[k+1], 1'b0, 1'b0, 1'b0);
    end
    drain();
    chk("b2b_accepts", accLog.size(), 32'd3);
    if (accLog.size() == 3) begin
      chk("b2b_spacing1", accLog[1] - accLog[0], 32'd4);
      chk("b2b_spacing2", accLog[2] - accLog[1], 32'd4);
    end

    // Reset during EXEC abandons the op
    issue(ALU_ADD, 5'd15, 5'd1, 5'd2, 1'b0, 16'h0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_exec_op", {26'd0, alu_op}, {26'd0, ALU_ADD});
    #1 rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, instr_ready}, 32'd1);
    chk("arst_alu", {26'd0, alu_op} | alu_regA | alu_regB, 32'd0);
    chk("arst_we_done", {30'd0, rf_we, done}, 32'd0);
    chk("arst_zero", {31'd0, zero_flag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dueQ.delete();
    zeroModel = 1'b0;
    repeat (5) @(negedge clk);
    issue(ALU_ADD, 5'd16, 5'd1, 5'd2, 1'b0, 16'h0000, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
